// File: rtl/p1v_plug_pkg.sv
// Shared types and default timing constants for the Prop plug host link.
package p1v_plug_pkg;

    localparam int unsigned CLK_HZ           = 160_000_000;
    localparam int unsigned BAUD             = 115_200;
    localparam int unsigned DEF_CLKS_PER_BIT = (CLK_HZ + (BAUD / 2)) / BAUD;
    localparam int unsigned DEF_RESET_CYCLES = 16_000;
    localparam int unsigned DEF_BOOT_WAIT    = 14_400_000;

    typedef enum logic [2:0] {
        ST_TX_IDLE   = 3'd0,
        ST_RST_PULSE = 3'd1,
        ST_BOOT_WAIT = 3'd2,
        ST_START     = 3'd3,
        ST_DATA      = 3'd4,
        ST_STOP      = 3'd5
    } plug_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/p1v_bit_timer.sv
// UART bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the last cycle.
module p1v_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1389
) (
    input  logic clock_160,
    input  logic inp_resn,
    input  logic clear,
    input  logic run,
    output logic bit_done
);

    localparam int unsigned    CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = run & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/prop_plug_host.sv
// Host side of the Prop plug: timed Propeller reset, boot-ROM wait, then 8N1 byte serializer.
module prop_plug_host
    import p1v_plug_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned BOOT_WAIT    = DEF_BOOT_WAIT
) (
    input  logic       clock_160,
    input  logic       inp_resn,
    input  logic       reset_req,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       resn_out,
    output logic       busy
);

    localparam int unsigned      SEQ_W     = $clog2(max_u(RESET_CYCLES, BOOT_WAIT) + 1);
    localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(RESET_CYCLES - 1);
    localparam logic [SEQ_W-1:0] BOOT_LAST = SEQ_W'(BOOT_WAIT - 1);

    plug_state_t      state_q;
    plug_state_t      state_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [SEQ_W-1:0] seq_cnt_q;
    logic [SEQ_W-1:0] seq_cnt_d;
    logic             tx_q;
    logic             tx_d;
    logic             resn_out_q;
    logic             resn_out_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic             busy_q;
    logic             busy_d;

    logic frame_active;
    logic bit_done;

    assign frame_active = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    // Timer restarts at zero on every accept because it is held clear outside a frame.
    p1v_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock_160 (clock_160),
        .inp_resn  (inp_resn),
        .clear     (reset_req | ~frame_active),
        .run       (frame_active),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q <= ST_TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath; reset_req overrides any handshake or frame in flight.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        seq_cnt_d = seq_cnt_q;
        if (reset_req) begin
            state_d   = ST_RST_PULSE;
            bit_idx_d = '0;
            seq_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_TX_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_d   = in_data;
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end
                end
                ST_RST_PULSE: begin
                    if (seq_cnt_q == RST_LAST) begin
                        seq_cnt_d = '0;
                        state_d   = ST_BOOT_WAIT;
                    end else begin
                        seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                    end
                end
                ST_BOOT_WAIT: begin
                    if (seq_cnt_q == BOOT_LAST) begin
                        seq_cnt_d = '0;
                        state_d   = ST_TX_IDLE;
                    end else begin
                        seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            shift_d   = {1'b0, shift_q[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        state_d = ST_TX_IDLE;
                    end
                end
                default: begin
                    state_d = ST_TX_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        tx_d       = 1'b1;
        resn_out_d = 1'b1;
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        unique case (state_d)
            ST_TX_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            ST_RST_PULSE: resn_out_d = 1'b0;
            ST_START:     tx_d       = 1'b0;
            ST_DATA:      tx_d       = shift_d[0];
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            seq_cnt_q  <= '0;
            tx_q       <= 1'b1;
            resn_out_q <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            seq_cnt_q  <= seq_cnt_d;
            tx_q       <= tx_d;
            resn_out_q <= resn_out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign resn_out = resn_out_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_prop_plug_host.sv
// Randomized and directed bench for prop_plug_host against a waveform-schedule reference model.
module tb_prop_plug_host;

    localparam int unsigned C  = 4;
    localparam int unsigned RC = 3;
    localparam int unsigned BW = 5;

    // Expected output vector: {tx, resn_out, in_ready, busy}
    localparam logic [3:0] E_RST   = 4'b1100;
    localparam logic [3:0] E_IDLE  = 4'b1110;
    localparam logic [3:0] E_PULSE = 4'b1001;
    localparam logic [3:0] E_BOOT  = 4'b1101;
    localparam logic [3:0] E_STOP  = 4'b1101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       reset_req = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       resn_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    prop_plug_host #(
        .CLKS_PER_BIT(C),
        .RESET_CYCLES(RC),
        .BOOT_WAIT   (BW)
    ) dut (
        .clock_160 (clk),
        .inp_resn  (rst_n),
        .reset_req (reset_req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .resn_out  (resn_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted event schedules the exact output waveform of the cycles that follow.
    logic [3:0] sched[$];
    logic [3:0] cur = E_RST;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched.delete();
            cur = E_RST;
        end else begin
            if (reset_req) begin
                sched.delete();
                for (int i = 0; i < int'(RC); i++) sched.push_back(E_PULSE);
                for (int i = 0; i < int'(BW); i++) sched.push_back(E_BOOT);
            end else if (in_valid && cur[1]) begin
                for (int i = 0; i < int'(C); i++) sched.push_back(4'b0101);
                for (int b = 0; b < 8; b++)
                    for (int i = 0; i < int'(C); i++) sched.push_back({in_data[b], 3'b101});
                for (int i = 0; i < int'(C); i++) sched.push_back(E_STOP);
            end
            cur = (sched.size() != 0) ? sched.pop_front() : E_IDLE;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({tx, resn_out, in_ready, busy} !== cur) begin
            errors++;
            $display("FAIL model_cycle t=%0t tx/resn/rdy/busy got=%b want=%b",
                     $time, {tx, resn_out, in_ready, busy}, cur);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(in_ready === 1'b1 && busy === 1'b0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, (n < 200) ? 1 : 0, 1);
    endtask

    // Offer one byte at the next edge, then sample tx/in_ready at negedges k=0..40 after the accept.
    task automatic send_capture(input logic [7:0] d, output logic [40:0] txv, output logic [40:0] rdyv);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 41; k++) begin
            txv[k]  = tx;
            rdyv[k] = in_ready;
            if (k < 40) tick();
        end
    endtask

    function automatic logic [7:0] decode(input logic [40:0] txv);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = txv[4 * i + 5];
        return b;
    endfunction

    initial begin
        logic [40:0] txv;
        logic [40:0] rdyv;
        int          cnt;
        int          first;
        int          z;
        int          o;
        int          a5_bits[10];

        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_tx", int'(tx), 1);
        #2 rst_n = 1'b1;
        tick();
        chk("first_edge_in_ready", int'(in_ready), 1);
        chk("first_edge_busy", int'(busy), 0);
        chk("first_edge_resn", int'(resn_out), 1);
        repeat (3) tick();

        // Single 0xA5 frame
        send_capture(8'hA5, txv, rdyv);
        for (int b = 0; b < 10; b++) chk($sformatf("a5_bit%0d", b), int'(txv[4 * b + 1]), a5_bits[b]);
        cnt = 0;
        for (int k = 0; k < 40; k++) if (!rdyv[k]) cnt++;
        chk("a5_ready_low_cycles", cnt, 40);
        chk("a5_ready_back_cycle41", int'(rdyv[40]), 1);
        wait_idle("a5");

        // Back-to-back 0x00 then 0xFF
        in_valid = 1'b1;
        in_data  = 8'h00;
        cnt = 0;
        do begin tick(); cnt++; end while (tx !== 1'b0 && cnt < 50);
        in_data = 8'hFF;
        z = 0;
        while (tx === 1'b0 && z < 100) begin z++; tick(); end
        o = 0;
        while (tx === 1'b1 && o < 100) begin o++; tick(); end
        in_valid = 1'b0;
        chk("b2b_zero_run", z, 36);
        chk("b2b_gap_high", o, 5);
        wait_idle("b2b");

        // reset_req wins over a same-cycle handshake, then pulse + boot wait
        tick();
        reset_req = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        tick();
        reset_req = 1'b0;
        cnt   = 0;
        first = -1;
        for (int k = 0; k < 30; k++) begin
            if (resn_out === 1'b0) cnt++;
            if (first < 0 && tx === 1'b0) begin
                first    = k;
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("pulse_resn_low_cycles", cnt, 3);
        chk("pulse_first_accept_edge", first, 9);
        wait_idle("pulse");

        // Abort 0x0F during data bit 3
        in_valid = 1'b1;
        in_data  = 8'h0F;
        tick();
        in_valid = 1'b0;
        repeat (17) tick();
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        chk("abort_tx_high", int'(tx), 1);
        chk("abort_resn_low", int'(resn_out), 0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (tx === 1'b0) cnt++;
            tick();
        end
        chk("abort_no_more_bits", cnt, 0);
        wait_idle("abort");

        // Asynchronous reset during DATA, then a clean frame
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx", int'(tx), 1);
        chk("async_resn", int'(resn_out), 1);
        chk("async_in_ready", int'(in_ready), 0);
        chk("async_busy", int'(busy), 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        send_capture(8'hC3, txv, rdyv);
        chk("post_rst_start", int'(txv[1]), 0);
        chk("post_rst_byte", int'(decode(txv)), 32'hC3);
        chk("post_rst_stop", int'(txv[37]), 1);
        wait_idle("post_rst");

        // Randomized traffic with occasional reset requests
        for (int i = 0; i < 600; i++) begin
            tick();
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            reset_req = ($urandom_range(0, 59) == 0);
        end
        tick();
        in_valid  = 1'b0;
        reset_req = 1'b0;
        wait_idle("random");
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
